user_tlp_encoder: RTL and testbench



---
 rtl/user_tlp_encoder_if.sv | 32 +++
 rtl/user_tlp_encoder.sv | 187 ++++++++++++++++++
 tb/tb_user_tlp_encoder.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_tlp_encoder_if.sv
// Requester Request (RQ) AXI-Stream channel between the TLP encoder (master)
// and the PCIe core (slave).
interface user_tlp_encoder_if #(
    parameter int C_DATA_WIDTH        = 64,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = 60
);
    logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata;
    logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep;
    logic                           s_axis_rq_tlast;
    logic                           s_axis_rq_tvalid;
    logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser;
    logic                           s_axis_rq_tready;

    modport master (
        output s_axis_rq_tdata,
        output s_axis_rq_tkeep,
        output s_axis_rq_tlast,
        output s_axis_rq_tvalid,
        output s_axis_rq_tuser,
        input  s_axis_rq_tready
    );

    modport slave (
        input  s_axis_rq_tdata,
        input  s_axis_rq_tkeep,
        input  s_axis_rq_tlast,
        input  s_axis_rq_tvalid,
        input  s_axis_rq_tuser,
        output s_axis_rq_tready
    );
endinterface

// File: rtl/user_tlp_encoder.sv
// Requester-request TLP encoder: single-DW MemRd/MemWr onto the RQ AXI-Stream.
// Define RQ_STALL_TIMEOUT_EN to build the tready stall watchdog behind tx_stall.
module user_tlp_encoder #(
    parameter int          TCQ                 = 1,
    parameter int          AXI4_RQ_TUSER_WIDTH = 60,
    parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
    parameter int          C_DATA_WIDTH        = 64,
    parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32
) (
    input  logic                      user_clk,
    input  logic                      reset_n,
    user_tlp_encoder_if.master        rq,
    input  logic                      tx_start,
    input  logic                      tx_type,
    input  logic [7:0]                tx_tag,
    input  logic [63:0]               tx_addr,
    input  logic [31:0]               tx_data,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic                      tx_stall
);
    // state | meaning
    // IDLE  | no command in flight, waiting for tx_start
    // BEAT0 | descriptor (128-bit) or descriptor DW0-1 (64-bit)
    // BEAT1 | payload (128-bit) or descriptor DW2-3 (64-bit)
    // BEAT2 | payload (64-bit only)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        BEAT2 = 2'd3
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         cmd_type;
    logic [7:0]   cmd_tag;
    logic [61:0]  cmd_addr;
    logic [31:0]  cmd_data;
    logic         done;
    logic         active;
    logic         accept;
    logic         last_beat;
    logic [127:0] desc;
    logic         unused_addr_lsb;

    if (C_DATA_WIDTH != 64 && C_DATA_WIDTH != 128) begin : g_bad_width
        $error("user_tlp_encoder: C_DATA_WIDTH must be 64 or 128");
    end
    if (KEEP_WIDTH != C_DATA_WIDTH / 32) begin : g_bad_keep
        $error("user_tlp_encoder: KEEP_WIDTH must equal C_DATA_WIDTH/32");
    end
    if (TCQ < 0) begin : g_bad_tcq
        $error("user_tlp_encoder: TCQ must be non-negative");
    end

    assign unused_addr_lsb = ^tx_addr[1:0];

    assign active = (state != IDLE);
    assign accept = active && rq.s_axis_rq_tready;

    if (C_DATA_WIDTH == 128) begin : g_last128
        assign last_beat = (state == BEAT1) || (state == BEAT0 && !cmd_type);
    end else begin : g_last64
        assign last_beat = (state == BEAT2) || (state == BEAT1 && !cmd_type);
    end

    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tx_start) state_nxt = BEAT0;
            BEAT0:   if (accept) state_nxt = last_beat ? IDLE : BEAT1;
            BEAT1:   if (accept) state_nxt = last_beat ? IDLE : BEAT2;
            BEAT2:   if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command is captured only from IDLE, so a strobe while busy is dropped.
    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            cmd_type <= 1'b0;
            cmd_tag  <= 8'h00;
            cmd_addr <= '0;
            cmd_data <= 32'h0;
            done     <= 1'b0;
        end else begin
            done <= accept && last_beat;
            if (state == IDLE && tx_start) begin
                cmd_type <= tx_type;
                cmd_tag  <= tx_tag;
                cmd_addr <= tx_addr[63:2];
                cmd_data <= tx_data;
            end
        end
    end

    assign desc = {1'b0, 3'b000, 3'b000, 1'b0, 16'h0000, cmd_tag, REQUESTER_ID,
                   1'b0, 3'b000, cmd_type, 11'd1, cmd_addr, 2'b00};

    assign tx_busy = active;
    assign tx_done = done;

    assign rq.s_axis_rq_tvalid = active;
    assign rq.s_axis_rq_tuser  = active ? AXI4_RQ_TUSER_WIDTH'(8'h0F) : '0;

    if (C_DATA_WIDTH == 128) begin : g_out128
        always_comb begin
            rq.s_axis_rq_tdata = '0;
            rq.s_axis_rq_tkeep = '0;
            rq.s_axis_rq_tlast = 1'b0;
            case (state)
                BEAT0: begin
                    rq.s_axis_rq_tdata = desc;
                    rq.s_axis_rq_tkeep = KEEP_WIDTH'(4'hF);
                    rq.s_axis_rq_tlast = !cmd_type;
                end
                BEAT1: begin
                    rq.s_axis_rq_tdata = {96'h0, cmd_data};
                    rq.s_axis_rq_tkeep = KEEP_WIDTH'(4'h1);
                    rq.s_axis_rq_tlast = 1'b1;
                end
                default: ;
            endcase
        end
    end else begin : g_out64
        always_comb begin
            rq.s_axis_rq_tdata = '0;
            rq.s_axis_rq_tkeep = '0;
            rq.s_axis_rq_tlast = 1'b0;
            case (state)
                BEAT0: begin
                    rq.s_axis_rq_tdata = desc[63:0];
                    rq.s_axis_rq_tkeep = KEEP_WIDTH'(2'b11);
                end
                BEAT1: begin
                    rq.s_axis_rq_tdata = desc[127:64];
                    rq.s_axis_rq_tkeep = KEEP_WIDTH'(2'b11);
                    rq.s_axis_rq_tlast = !cmd_type;
                end
                BEAT2: begin
                    rq.s_axis_rq_tdata = {32'h0, cmd_data};
                    rq.s_axis_rq_tkeep = KEEP_WIDTH'(2'b01);
                    rq.s_axis_rq_tlast = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef RQ_STALL_TIMEOUT_EN
    logic [15:0] stall_cnt;
    logic        stall_flag;

    // Flag is sticky across the rest of the packet; only a new command clears it.
    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            stall_cnt  <= 16'h0000;
            stall_flag <= 1'b0;
        end else begin
            if (!active || accept) begin
                stall_cnt <= 16'h0000;
            end else if (stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (state == IDLE && tx_start) begin
                stall_flag <= 1'b0;
            end else if (stall_cnt == 16'hFFFF) begin
                stall_flag <= 1'b1;
            end
        end
    end

    assign tx_stall = stall_flag;
`else
    assign tx_stall = 1'b0;
`endif

endmodule

// File: tb/tb_user_tlp_encoder.sv
// Self-checking bench: a 64-bit and a 128-bit encoder against a DW-list packet model.
module tb_user_tlp_encoder;
    localparam logic [15:0] RID = 16'h10EE;
`ifdef RQ_STALL_TIMEOUT_EN
    localparam int   LONG_STALL = 65540;
    localparam logic EXP_STALL  = 1'b1;
`else
    localparam int   LONG_STALL = 300;
    localparam logic EXP_STALL  = 1'b0;
`endif

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
        logic [59:0]  u;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_v [2];
    logic        type_v  [2];
    logic [7:0]  tag_v   [2];
    logic [63:0] addr_v  [2];
    logic [31:0] data_v  [2];
    logic        tready_v[2];
    logic        busy64, done64, stall64;
    logic        busy128, done128, stall128;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t obs_q[$];
    beat_t exp_q[$];
    int    obs_lat, obs_bad, obs_unstable, obs_stalls;

    user_tlp_encoder_if #(.C_DATA_WIDTH(64), .KEEP_WIDTH(2), .AXI4_RQ_TUSER_WIDTH(60)) rq64 ();
    user_tlp_encoder_if #(.C_DATA_WIDTH(128), .KEEP_WIDTH(4), .AXI4_RQ_TUSER_WIDTH(60)) rq128 ();

    assign rq64.s_axis_rq_tready  = tready_v[0];
    assign rq128.s_axis_rq_tready = tready_v[1];

    user_tlp_encoder #(.C_DATA_WIDTH(64), .KEEP_WIDTH(2)) dut64 (
        .user_clk (clk),
        .reset_n  (rst_n),
        .rq       (rq64),
        .tx_start (start_v[0]),
        .tx_type  (type_v[0]),
        .tx_tag   (tag_v[0]),
        .tx_addr  (addr_v[0]),
        .tx_data  (data_v[0]),
        .tx_busy  (busy64),
        .tx_done  (done64),
        .tx_stall (stall64)
    );

    user_tlp_encoder #(.C_DATA_WIDTH(128), .KEEP_WIDTH(4)) dut128 (
        .user_clk (clk),
        .reset_n  (rst_n),
        .rq       (rq128),
        .tx_start (start_v[1]),
        .tx_type  (type_v[1]),
        .tx_tag   (tag_v[1]),
        .tx_addr  (addr_v[1]),
        .tx_data  (data_v[1]),
        .tx_busy  (busy128),
        .tx_done  (done128),
        .tx_stall (stall128)
    );

    // s = 0 selects the 64-bit encoder, s = 1 the 128-bit one.
    function automatic void get_out(input int s, output beat_t b, output logic tv, bz, dn, st);
        b = '0;
        if (s == 0) begin
            b.d = {64'h0, rq64.s_axis_rq_tdata};
            b.k = {2'b00, rq64.s_axis_rq_tkeep};
            b.l = rq64.s_axis_rq_tlast;
            b.u = rq64.s_axis_rq_tuser;
            tv  = rq64.s_axis_rq_tvalid;
            bz  = busy64;
            dn  = done64;
            st  = stall64;
        end else begin
            b.d = rq128.s_axis_rq_tdata;
            b.k = rq128.s_axis_rq_tkeep;
            b.l = rq128.s_axis_rq_tlast;
            b.u = rq128.s_axis_rq_tuser;
            tv  = rq128.s_axis_rq_tvalid;
            bz  = busy128;
            dn  = done128;
            st  = stall128;
        end
    endfunction

    // Reference: the TLP is a list of DWs (4-DW descriptor, then payload for a write),
    // cut into beats of C_DATA_WIDTH/32 DWs.
    function automatic void build_exp(input int s, input logic typ, input logic [7:0] tag,
                                      input logic [63:0] addr, input logic [31:0] data);
        logic [31:0] dw[$];
        int          per;
        beat_t       b;
        per = (s == 0) ? 2 : 4;
        dw  = {};
        dw.push_back({addr[31:2], 2'b00});
        dw.push_back(addr[63:32]);
        dw.push_back({RID, 1'b0, 3'b000, typ, 11'd1});
        dw.push_back({24'h0, tag});
        if (typ) dw.push_back(data);
        exp_q = {};
        for (int i = 0; i < dw.size(); i += per) begin
            b = '0;
            for (int j = 0; j < per; j++) begin
                if (i + j < dw.size()) begin
                    b.d[32*j +: 32] = dw[i+j];
                    b.k[j]          = 1'b1;
                end
            end
            b.l = (i + per >= dw.size());
            b.u = 60'h0F;
            exp_q.push_back(b);
        end
    endfunction

    // Must be entered at a negedge; leaves at the negedge of the tx_done cycle,
    // so consecutive calls issue the next command at the earliest legal edge.
    task automatic send_pkt(input int s, input logic typ, input logic [7:0] tag, input logic [63:0] addr,
                            input logic [31:0] data, input int stall_beat, input int stall_len,
                            input bit rnd, input bit dup);
        beat_t b, prev;
        logic  tv, bz, dn, st, ready;
        int    cyc, left;
        bit    fin, held;
        obs_q = {};
        obs_lat = -1; obs_bad = 0; obs_unstable = 0; obs_stalls = 0;
        cyc = 0; left = stall_len; fin = 1'b0; held = 1'b0; prev = '0;
        start_v[s] = 1'b1; type_v[s] = typ; tag_v[s] = tag; addr_v[s] = addr; data_v[s] = data;
        tready_v[s] = 1'b1;
        while (!fin && cyc < stall_len + 100) begin
            @(negedge clk);
            cyc++;
            start_v[s] = dup && (cyc == 1);
            if (start_v[s]) begin
                type_v[s] = ~typ; tag_v[s] = tag ^ 8'hA5; addr_v[s] = ~addr; data_v[s] = ~data;
            end
            get_out(s, b, tv, bz, dn, st);
            if (tv === 1'b1) begin
                if (bz !== 1'b1 || dn !== 1'b0) obs_bad++;
                if (held && b !== prev) obs_unstable++;
                if (rnd) ready = ($urandom_range(0, 3) != 0);
                else     ready = !(obs_q.size() == stall_beat && left > 0);
                if (!ready) begin
                    left--;
                    obs_stalls++;
                end else begin
                    obs_q.push_back(b);
                end
                tready_v[s] = ready;
                held = !ready;
                prev = b;
            end else if (dn === 1'b1 && bz === 1'b0) begin
                obs_lat = cyc;
                fin = 1'b1;
            end else begin
                obs_bad++;
            end
        end
        start_v[s] = 1'b0;
        tready_v[s] = 1'b1;
    endtask

    task automatic test_reset();
        beat_t b;
        logic  tv, bz, dn, st;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_v[s] = 1'b0; type_v[s] = 1'b0; tag_v[s] = 8'h0; addr_v[s] = 64'h0;
            data_v[s] = 32'h0; tready_v[s] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            get_out(s, b, tv, bz, dn, st);
            n_checks++;
            if (b !== '0 || {tv, bz, dn, st} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset w%0d: got data %h keep %h last %b user %h v/b/d/s %b%b%b%b want all 0",
                         s, b.d, b.k, b.l, b.u, tv, bz, dn, st);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        logic [7:0]  tag;
        logic [63:0] addr;
        for (int s = 1; s >= 0; s--) begin
            tag  = (s == 1) ? 8'h05 : 8'($urandom);
            addr = (s == 1) ? 64'h0000_0000_F000_1004 : {$urandom, $urandom};
            send_pkt(s, 1'b0, tag, addr, 32'h0, 0, 0, 1'b0, 1'b0);
            build_exp(s, 1'b0, tag, addr, 32'h0);
            n_checks++;
            if (obs_lat !== ((s == 1) ? 2 : 3)) begin
                n_fail++;
                $display("FAIL read_latency w%0d: got %0d want %0d", s, obs_lat, (s == 1) ? 2 : 3);
            end
            n_checks++;
            if (obs_bad !== 0) begin
                n_fail++;
                $display("FAIL read_protocol w%0d: got %0d violations want 0", s, obs_bad);
            end
            n_checks++;
            if (obs_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL read_beats w%0d: got %0d want %0d", s, obs_q.size(), exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    n_checks++;
                    if (obs_q[j] !== exp_q[j]) begin
                        n_fail++;
                        $display("FAIL read_beat%0d w%0d: got %h/%h/%b/%h want %h/%h/%b/%h", j, s,
                                 obs_q[j].d, obs_q[j].k, obs_q[j].l, obs_q[j].u,
                                 exp_q[j].d, exp_q[j].k, exp_q[j].l, exp_q[j].u);
                    end
                end
            end
        end
    endtask

    task automatic test_write();
        int          s, sl, lat;
        logic [7:0]  tag;
        logic [63:0] addr;
        logic [31:0] data;
        // 128-bit plain, 64-bit plain, 64-bit with tready low for 5 cycles in BEAT1
        for (int i = 0; i < 3; i++) begin
            s    = (i == 0) ? 1 : 0;
            sl   = (i == 2) ? 5 : 0;
            lat  = (i == 0) ? 3 : ((i == 1) ? 4 : 9);
            tag  = 8'($urandom);
            addr = {$urandom, $urandom};
            data = (i == 0) ? 32'hDEAD_BEEF : $urandom;
            send_pkt(s, 1'b1, tag, addr, data, 1, sl, 1'b0, 1'b0);
            build_exp(s, 1'b1, tag, addr, data);
            n_checks++;
            if (obs_lat !== lat) begin
                n_fail++;
                $display("FAIL write%0d_latency: got %0d want %0d", i, obs_lat, lat);
            end
            n_checks++;
            if (obs_bad !== 0 || obs_unstable !== 0 || obs_stalls !== sl) begin
                n_fail++;
                $display("FAIL write%0d_protocol: got viol %0d unstable %0d stalls %0d want 0 0 %0d",
                         i, obs_bad, obs_unstable, obs_stalls, sl);
            end
            n_checks++;
            if (obs_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL write%0d_beats: got %0d want %0d", i, obs_q.size(), exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    n_checks++;
                    if (obs_q[j] !== exp_q[j]) begin
                        n_fail++;
                        $display("FAIL write%0d_beat%0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, j,
                                 obs_q[j].d, obs_q[j].k, obs_q[j].l, obs_q[j].u,
                                 exp_q[j].d, exp_q[j].k, exp_q[j].l, exp_q[j].u);
                    end
                end
            end
        end
    endtask

    task automatic test_dup_start();
        logic [7:0]  tag;
        logic [63:0] addr;
        logic [31:0] data;
        for (int s = 0; s < 2; s++) begin
            tag = 8'($urandom); addr = {$urandom, $urandom}; data = $urandom;
            send_pkt(s, 1'b1, tag, addr, data, 0, 0, 1'b0, 1'b1);
            build_exp(s, 1'b1, tag, addr, data);
            n_checks++;
            if (obs_lat !== ((s == 1) ? 3 : 4) || obs_bad !== 0) begin
                n_fail++;
                $display("FAIL dup_start_timing w%0d: got lat %0d viol %0d want %0d 0",
                         s, obs_lat, obs_bad, (s == 1) ? 3 : 4);
            end
            n_checks++;
            if (obs_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL dup_start_beats w%0d: got %0d want %0d", s, obs_q.size(), exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    n_checks++;
                    if (obs_q[j] !== exp_q[j]) begin
                        n_fail++;
                        $display("FAIL dup_start_beat%0d w%0d: got %h want %h", j, s, obs_q[j].d, exp_q[j].d);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int          s;
        logic        typ;
        logic [7:0]  tag;
        logic [63:0] addr;
        logic [31:0] data;
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1); typ = 1'($urandom);
            tag = 8'($urandom); addr = {$urandom, $urandom}; data = $urandom;
            send_pkt(s, typ, tag, addr, data, 0, 0, 1'b1, 1'b0);
            build_exp(s, typ, tag, addr, data);
            n_checks++;
            if (obs_lat !== exp_q.size() + obs_stalls + 1 || obs_bad !== 0 || obs_unstable !== 0) begin
                n_fail++;
                $display("FAIL random%0d_timing w%0d: got lat %0d viol %0d unstable %0d want lat %0d",
                         i, s, obs_lat, obs_bad, obs_unstable, exp_q.size() + obs_stalls + 1);
            end
            n_checks++;
            if (obs_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL random%0d_beats w%0d: got %0d want %0d", i, s, obs_q.size(), exp_q.size());
            end else begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    n_checks++;
                    if (obs_q[j] !== exp_q[j]) begin
                        n_fail++;
                        $display("FAIL random%0d_beat%0d w%0d: got %h/%h/%b want %h/%h/%b", i, j, s,
                                 obs_q[j].d, obs_q[j].k, obs_q[j].l, exp_q[j].d, exp_q[j].k, exp_q[j].l);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t       b;
        logic        tv, bz, dn, st;
        logic [7:0]  tag;
        logic [63:0] addr;
        logic [31:0] data;
        tag = 8'($urandom); addr = {$urandom, $urandom}; data = $urandom;
        start_v[0] = 1'b1; type_v[0] = 1'b1; tag_v[0] = tag; addr_v[0] = addr; data_v[0] = data;
        tready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        get_out(0, b, tv, bz, dn, st);
        n_checks++;
        if (tv !== 1'b1 || b.k !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_mid_beat1: got valid %b keep %h want 1 3", tv, b.k);
        end
        rst_n = 1'b0;
        @(negedge clk);
        get_out(0, b, tv, bz, dn, st);
        n_checks++;
        if (b !== '0 || {tv, bz, dn, st} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got data %h keep %h last %b v/b/d/s %b%b%b%b want all 0",
                     b.d, b.k, b.l, tv, bz, dn, st);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tag = 8'($urandom); addr = {$urandom, $urandom}; data = $urandom;
        send_pkt(0, 1'b1, tag, addr, data, 0, 0, 1'b0, 1'b0);
        build_exp(0, 1'b1, tag, addr, data);
        n_checks++;
        if (obs_lat !== 4 || obs_bad !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got lat %0d viol %0d want 4 0", obs_lat, obs_bad);
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_mid_beats: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int j = 0; j < exp_q.size(); j++) begin
                n_checks++;
                if (obs_q[j] !== exp_q[j]) begin
                    n_fail++;
                    $display("FAIL reset_mid_beat%0d: got %h want %h", j, obs_q[j].d, exp_q[j].d);
                end
            end
        end
    endtask

    task automatic test_stall_watchdog();
        beat_t b;
        logic  tv, bz, dn, st;
        send_pkt(0, 1'b1, 8'h3C, {$urandom, $urandom}, $urandom, 1, 1000, 1'b0, 1'b0);
        get_out(0, b, tv, bz, dn, st);
        n_checks++;
        if (obs_lat !== 1004 || st !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_short: got lat %0d stall %b want 1004 0", obs_lat, st);
        end
        send_pkt(0, 1'b1, 8'h3D, {$urandom, $urandom}, $urandom, 1, LONG_STALL, 1'b0, 1'b0);
        get_out(0, b, tv, bz, dn, st);
        n_checks++;
        if (obs_lat !== LONG_STALL + 4 || obs_bad !== 0 || obs_unstable !== 0) begin
            n_fail++;
            $display("FAIL stall_long_packet: got lat %0d viol %0d unstable %0d want %0d 0 0",
                     obs_lat, obs_bad, obs_unstable, LONG_STALL + 4);
        end
        n_checks++;
        if (st !== EXP_STALL) begin
            n_fail++;
            $display("FAIL stall_flag_set: got %b want %b", st, EXP_STALL);
        end
        @(negedge clk);
        get_out(0, b, tv, bz, dn, st);
        n_checks++;
        if (st !== EXP_STALL) begin
            n_fail++;
            $display("FAIL stall_flag_sticky: got %b want %b", st, EXP_STALL);
        end
        send_pkt(0, 1'b0, 8'h3E, {$urandom, $urandom}, 32'h0, 0, 0, 1'b0, 1'b0);
        get_out(0, b, tv, bz, dn, st);
        n_checks++;
        if (st !== 1'b0 || obs_lat !== 3) begin
            n_fail++;
            $display("FAIL stall_flag_clear: got stall %b lat %0d want 0 3", st, obs_lat);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_dup_start();
        test_random();
        test_reset_mid();
        test_stall_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
